uart_word_loader: RTL and testbench

Serial front end that feeds the datapath's UART load port. It receives 8N1 bytes on the `rx` pin and assembles three-byte frames (header, data high, data low) into 16-bit words. Each completed frame produces a one-cycle `uart_en` strobe together with `uart_sel`/`uart_data`, which the datapath consumes to load instruction memory (sel 3) or data memory (sel 1). It sits directly upstream of the datapath's `uart_en`/`uart_sel`/`uart_data` inputs.

---
 rtl/uart_loader_pkg.sv | 16 +
 rtl/uart_rx_byte.sv | 113 +++++++++++
 rtl/uart_word_loader.sv | 119 +++++++++++
 tb/tb_uart_word_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART word loader (byte receiver + frame assembler).
package uart_loader_pkg;

  localparam logic [1:0] SEL_INST  = 2'd3;
  localparam logic [1:0] SEL_MEM   = 2'd1;
  localparam logic [5:0] HDR_MAGIC = 6'b101000;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} byteState_t;
  typedef enum logic [1:0] {HDR, HI, LO} asmState_t;

  // Clock divider for one oversample tick, rounded to nearest.
  function automatic int divFor(input int clkHz, input int baud, input int os);
    return (clkHz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampling serial byte receiver: rx synchronizer, tick divider, bit FSM.
// UART_LOADER_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int DIV   = divFor(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TW-1:0]    HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]    BIT_LAST  = TW'(OVERSAMPLE - 1);

  byteState_t       state, stateNext;
  logic             sync0, sync1, rxPrev;
  logic [DIV_W-1:0] divCnt;
  logic [TW-1:0]    tickCnt;
  logic [2:0]       bitCnt;
  logic [7:0]       shiftReg;
  logic             tick, halfEnd, bitEnd;
  logic             sampleBit, stopOk, stopBad;
  logic             parErr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0  <= 1'b1;
      sync1  <= 1'b1;
      rxPrev <= 1'b1;
      divCnt <= '0;
    end else begin
      sync0  <= rx;
      sync1  <= sync0;
      rxPrev <= sync1;
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + DIV_W'(1);
    end
  end

  assign tick    = (divCnt == DIV_LAST);
  assign halfEnd = tick && (tickCnt == HALF_LAST);
  assign bitEnd  = tick && (tickCnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (rxPrev && !sync1) stateNext = START;
      START: if (halfEnd) stateNext = sync1 ? IDLE : DATA;
`ifdef UART_LOADER_PARITY_EN
      DATA:   if (bitEnd && bitCnt == 3'd7) stateNext = PARITY;
      PARITY: if (bitEnd) stateNext = STOP;
`else
      DATA:   if (bitEnd && bitCnt == 3'd7) stateNext = STOP;
`endif
      STOP:  if (bitEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    sampleBit = (state == DATA) && bitEnd;
    stopOk    = (state == STOP) && bitEnd && sync1 && !parErr;
    stopBad   = (state == STOP) && bitEnd && !(sync1 && !parErr);
  end

  // Tick phase restarts on every state change so each bit is sampled mid-cell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickCnt    <= '0;
      bitCnt     <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      if (state == IDLE || state != stateNext || bitEnd) tickCnt <= '0;
      else if (tick)                                     tickCnt <= tickCnt + TW'(1);
      if (state != DATA) bitCnt <= '0;
      else if (bitEnd)   bitCnt <= bitCnt + 3'd1;
      byte_valid <= stopOk;
      byte_err   <= stopBad;
    end
  end

`ifdef UART_LOADER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           parErr <= 1'b0;
    else if (state == PARITY && bitEnd)  parErr <= sync1 ^ (^shiftReg);
    else if (state == IDLE)              parErr <= 1'b0;
  end
`else
  assign parErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (sampleBit) shiftReg <= {sync1, shiftReg[7:1]};
  end

  assign byte_data = shiftReg;

endmodule

// File: rtl/uart_word_loader.sv
// Assembles {header, hi, lo} serial frames into 16-bit load words for the datapath.
// Optional even parity per byte via UART_LOADER_PARITY_EN.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        uart_en,
  output logic [1:0]  uart_sel,
  output logic [15:0] uart_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int TO_CLKS = TIMEOUT_BITS * OVERSAMPLE * divFor(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TO_W    = $clog2(TO_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CLKS - 1);

  logic            byteValid, byteErr;
  logic [7:0]      byteData;
  asmState_t       state, stateNext;
  logic [TO_W-1:0] toCnt;
  logic            timeout, hdrMatch;
  logic            enNext, errNext, latchSel, latchHi;
  logic [1:0]      selHold;
  logic [7:0]      hiHold;

  uart_rx_byte #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) rxByte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byteValid),
    .byte_data (byteData),
    .byte_err  (byteErr)
  );

  assign hdrMatch = (byteData[7:2] == HDR_MAGIC);
  assign timeout  = (state != HDR) && (toCnt == TO_LAST);
  assign busy     = (state != HDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HDR;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      HDR: if (byteValid && hdrMatch) stateNext = HI;
      HI: begin
        if (byteErr || (timeout && !byteValid)) stateNext = HDR;
        else if (byteValid)                     stateNext = LO;
      end
      LO: if (byteErr || byteValid || timeout) stateNext = HDR;
      default: stateNext = HDR;
    endcase
  end

  always_comb begin
    enNext   = 1'b0;
    errNext  = 1'b0;
    latchSel = 1'b0;
    latchHi  = 1'b0;
    case (state)
      HDR: begin
        latchSel = byteValid && hdrMatch;
        errNext  = byteErr || (byteValid && !hdrMatch);
      end
      HI: begin
        latchHi = byteValid;
        errNext = byteErr || (timeout && !byteValid);
      end
      LO: begin
        enNext  = byteValid;
        errNext = byteErr || (timeout && !byteValid);
      end
      default: ;
    endcase
  end

  // Idle-time counter only runs mid-frame; any received byte restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          toCnt <= '0;
    else if (state == HDR || byteValid) toCnt <= '0;
    else                                toCnt <= toCnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (latchSel) selHold <= byteData[1:0];
    if (latchHi)  hiHold  <= byteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_en   <= 1'b0;
      frame_err <= 1'b0;
      uart_sel  <= '0;
      uart_data <= '0;
    end else begin
      uart_en   <= enNext;
      frame_err <= errNext;
      if (enNext) begin
        uart_sel  <= selHold;
        uart_data <= {hiHold, byteData};
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: frames, errors, timeout, reset and glitch rejection.
module tb_uart_word_loader;

  localparam int CLK_HZ   = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int TO_BITS  = 40;
  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        uart_en, busy, frame_err;
  logic [1:0]  uart_sel;
  logic [15:0] uart_data;

  int tests = 0, failed = 0;
  int enCount = 0, errCount = 0, bothCount = 0, longEn = 0;
  logic prevEn = 1'b0;
  logic [1:0]  selLog [0:15];
  logic [15:0] dataLog[0:15];

  always #5 clk = ~clk;

  uart_word_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OS),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .uart_en  (uart_en),
    .uart_sel (uart_sel),
    .uart_data(uart_data),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (uart_en && frame_err) bothCount++;
    if (uart_en && prevEn) longEn++;
    prevEn = uart_en;
    if (uart_en) begin
      if (enCount < 16) begin
        selLog[enCount]  = uart_sel;
        dataLog[enCount] = uart_data;
      end
      enCount++;
    end
    if (frame_err) errCount++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idleBits(input int n);
    rx = 1'b1;
    waitClks(n * BIT_CLKS);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    waitClks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitClks(BIT_CLKS);
    end
`ifdef UART_LOADER_PARITY_EN
    rx = ^b;
    waitClks(BIT_CLKS);
`endif
    rx = stopBit;
    waitClks(BIT_CLKS);
  endtask

  task automatic sendFrame(input logic [7:0] h, input logic [7:0] hi, input logic [7:0] lo);
    sendByte(h, 1'b1);
    sendByte(hi, 1'b1);
    sendByte(lo, 1'b1);
  endtask

  initial begin
    waitClks(3);
    checkVal("rst_en", uart_en, 0);
    checkVal("rst_sel", uart_sel, 0);
    checkVal("rst_data", uart_data, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_err", frame_err, 0);
    reset = 1'b0;
    idleBits(2);

    // Single instruction-memory word
    sendByte(8'hA3, 1'b1);
    checkVal("busy_mid", busy, 1);
    sendByte(8'h12, 1'b1);
    sendByte(8'h34, 1'b1);
    checkVal("f1_count", enCount, 1);
    checkVal("f1_sel", selLog[0], 3);
    checkVal("f1_data", dataLog[0], 16'h1234);
    checkVal("f1_busy", busy, 0);
    checkVal("f1_err", errCount, 0);

    // Back-to-back frames, no idle between them
    sendFrame(8'hA1, 8'hBE, 8'hEF);
    sendFrame(8'hA3, 8'h00, 8'h01);
    checkVal("b2b_count", enCount, 3);
    checkVal("b2b_sel0", selLog[1], 1);
    checkVal("b2b_data0", dataLog[1], 16'hBEEF);
    checkVal("b2b_sel1", selLog[2], 3);
    checkVal("b2b_data1", dataLog[2], 16'h0001);

    // Bad header then a good frame
    idleBits(1);
    sendByte(8'h55, 1'b1);
    checkVal("badhdr_err", errCount, 1);
    checkVal("badhdr_busy", busy, 0);
    sendFrame(8'hA1, 8'h00, 8'hFF);
    checkVal("badhdr_count", enCount, 4);
    checkVal("badhdr_sel", selLog[3], 1);
    checkVal("badhdr_data", dataLog[3], 16'h00FF);
    checkVal("badhdr_err2", errCount, 1);

    // Low stop bit on the high byte
    sendByte(8'hA3, 1'b1);
    sendByte(8'h12, 1'b0);
    idleBits(2);
    checkVal("stop_err", errCount, 2);
    checkVal("stop_noen", enCount, 4);
    checkVal("stop_busy", busy, 0);
    sendFrame(8'hA1, 8'h12, 8'h34);
    checkVal("stop_count", enCount, 5);
    checkVal("stop_sel", selLog[4], 1);
    checkVal("stop_data", dataLog[4], 16'h1234);

    // Mid-frame timeout
    sendByte(8'hA3, 1'b1);
    sendByte(8'h12, 1'b1);
    idleBits(30);
    checkVal("to_busy_early", busy, 1);
    checkVal("to_err_early", errCount, 2);
    idleBits(20);
    checkVal("to_err", errCount, 3);
    checkVal("to_busy", busy, 0);
    checkVal("to_noen", enCount, 5);
    sendFrame(8'hA3, 8'hAB, 8'hCD);
    checkVal("to_count", enCount, 6);
    checkVal("to_sel", selLog[5], 3);
    checkVal("to_data", dataLog[5], 16'hABCD);

    // Reset during the high byte
    sendByte(8'hA3, 1'b1);
    checkVal("rst2_busy_pre", busy, 1);
    rx = 1'b0;
    waitClks(3 * BIT_CLKS);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("rst2_en", uart_en, 0);
    checkVal("rst2_sel", uart_sel, 0);
    checkVal("rst2_data", uart_data, 0);
    checkVal("rst2_busy", busy, 0);
    checkVal("rst2_err", frame_err, 0);
    @(negedge clk);
    rx = 1'b1;
    waitClks(3);
    reset = 1'b0;
    idleBits(12);
    checkVal("rst2_noen", enCount, 6);
    checkVal("rst2_noerr", errCount, 3);

    // One-tick low glitch on the line
    rx = 1'b0;
    waitClks(4);
    idleBits(3);
    checkVal("glitch_err", errCount, 3);
    checkVal("glitch_busy", busy, 0);
    sendFrame(8'hA3, 8'h5A, 8'hA5);
    checkVal("glitch_count", enCount, 7);
    checkVal("glitch_data", dataLog[6], 16'h5AA5);

    checkVal("en_err_overlap", bothCount, 0);
    checkVal("en_width", longEn, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
